// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser: "letter [digit [digit]] CR|LF" -> one-cycle action/error pulses.
// Optional inter-byte timeout is built only when CMD_TIMEOUT_EN is defined.
module uart_cmd_parser #(
    parameter int unsigned MAX_ARG        = 15,
    parameter int unsigned DEFAULT_ARG    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [3:0] cmd_arg,
    output logic       cmd_err,
    output logic [1:0] err_code,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ARG1,
        S_ARG2,
        S_ERR
    } state_e;

    localparam logic [6:0] MAX_ARG_C     = 7'(MAX_ARG);
    localparam logic [6:0] DEFAULT_ARG_C = 7'(DEFAULT_ARG);

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    state_e     state_q, state_d;
    logic [7:0] rx_prev_q;
    logic [2:0] code_q, code_d;
    logic [6:0] arg_q, arg_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [2:0] cmd_code_q, cmd_code_d;
    logic [3:0] cmd_arg_q, cmd_arg_d;
    logic [1:0] err_code_q, err_code_d;

    logic       byte_stb;
    logic       is_term;
    logic       is_space;
    logic       is_digit;
    logic [3:0] digit;
    logic [7:0] upper;
    logic [2:0] letter_code;

    logic       emit;
    logic [6:0] emit_arg;
    logic       syntax_done;
    logic       timeout_fire;

`ifdef CMD_TIMEOUT_EN
    localparam logic [24:0] TIMEOUT_LAST = 25'(TIMEOUT_CYCLES - 1);
    logic [24:0] cnt_q, cnt_d;
`endif

    assign byte_stb = (rx_byte != '0) && (rx_prev_q == '0);
    assign is_term  = (rx_byte == CH_CR) || (rx_byte == CH_LF);
    assign is_space = (rx_byte == CH_SPACE);
    assign is_digit = (rx_byte >= CH_ZERO) && (rx_byte <= CH_NINE);
    assign digit    = rx_byte[3:0];
    // Clearing bit 5 folds lower-case ASCII letters onto upper case.
    assign upper    = rx_byte & 8'hDF;

    always_comb begin
        letter_code = 3'd0;
        if (rx_byte[6]) begin
            case (upper)
                8'h46:   letter_code = 3'd1;
                8'h50:   letter_code = 3'd2;
                8'h43:   letter_code = 3'd3;
                8'h4D:   letter_code = 3'd4;
                8'h53:   letter_code = 3'd5;
                8'h52:   letter_code = 3'd6;
                default: letter_code = 3'd0;
            endcase
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rx_prev_q  <= '0;
            code_q     <= '0;
            arg_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            cmd_code_q <= '0;
            cmd_arg_q  <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            rx_prev_q  <= rx_byte;
            code_q     <= code_d;
            arg_q      <= arg_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            cmd_code_q <= cmd_code_d;
            cmd_arg_q  <= cmd_arg_d;
            err_code_q <= err_code_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 25'd1;
        if (byte_stb || (state_q == S_IDLE)) begin
            cnt_d = '0;
        end
    end

    // A byte strobe in the expiry cycle takes priority over the timeout.
    assign timeout_fire = !byte_stb && (state_q != S_IDLE) && (cnt_q == TIMEOUT_LAST);
`else
    assign timeout_fire = 1'b0;
`endif

    // Next-state and parse datapath.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        arg_d       = arg_q;
        emit        = 1'b0;
        emit_arg    = arg_q;
        syntax_done = 1'b0;

        if (byte_stb) begin
            case (state_q)
                S_IDLE: begin
                    if (is_term || is_space) begin
                        state_d = S_IDLE;
                    end else if (letter_code != 3'd0) begin
                        code_d  = letter_code;
                        arg_d   = '0;
                        state_d = S_CMD;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_CMD: begin
                    if (is_digit) begin
                        arg_d   = {3'b000, digit};
                        state_d = S_ARG1;
                    end else if (is_term) begin
                        emit     = 1'b1;
                        emit_arg = DEFAULT_ARG_C;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_ARG1: begin
                    if (is_digit) begin
                        arg_d   = 7'(arg_q * 7'd10 + {3'b000, digit});
                        state_d = S_ARG2;
                    end else if (is_term) begin
                        emit    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_ARG2: begin
                    if (is_term) begin
                        emit    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    if (is_term) begin
                        syntax_done = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (timeout_fire) begin
            state_d = S_IDLE;
        end
    end

    // Output next values: pulses plus the held code/arg/err_code.
    always_comb begin
        valid_d    = 1'b0;
        err_d      = 1'b0;
        cmd_code_d = cmd_code_q;
        cmd_arg_d  = cmd_arg_q;
        err_code_d = err_code_q;

        if (emit) begin
            if (emit_arg > MAX_ARG_C) begin
                err_d      = 1'b1;
                err_code_d = 2'd2;
            end else begin
                valid_d    = 1'b1;
                cmd_code_d = code_q;
                cmd_arg_d  = emit_arg[3:0];
            end
        end else if (syntax_done) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
        end else if (timeout_fire) begin
            err_d      = 1'b1;
            err_code_d = 2'd3;
        end
    end

    assign cmd_valid = valid_q;
    assign cmd_err   = err_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_arg   = cmd_arg_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != S_IDLE);

endmodule
